// File: rtl/game_fsm_mp_if.sv
// Player/boss status inputs and game-flow status outputs of the N-player game controller.
// master = player-state/gameplay side, slave = game_fsm_mp.
interface game_fsm_mp_if #(
    parameter int N_PLAYERS = 2,
    parameter int HP_W      = 4,
    parameter int BOSS_HP_W = 7
);
    logic [N_PLAYERS-1:0]      start_req;
    logic                      pause_req;
    logic [N_PLAYERS*HP_W-1:0] player_hp;
    logic [BOSS_HP_W-1:0]      boss_hp;
    logic [2:0]                game_state;
    logic                      game_result;
    logic [3:0]                countdown;
    logic [N_PLAYERS-1:0]      alive_mask;
    logic                      state_entry;

    modport master (
        output start_req, pause_req, player_hp, boss_hp,
        input  game_state, game_result, countdown, alive_mask, state_entry
    );

    modport slave (
        input  start_req, pause_req, player_hp, boss_hp,
        output game_state, game_result, countdown, alive_mask, state_entry
    );
endinterface

// File: rtl/game_fsm_mp.sv
// N-player game flow controller: MENU -> COUNTDOWN -> GAME <-> PAUSE -> END_SCREEN.
// All outputs are registered; a condition seen in cycle t is reflected in cycle t+1.
module game_fsm_mp #(
    parameter int          N_PLAYERS       = 2,
    parameter int          HP_W            = 4,
    parameter int          BOSS_HP_W       = 7,
    parameter int unsigned TICKS_PER_SEC   = 65_000_000,
    parameter int unsigned COUNTDOWN_S     = 3,
    parameter int unsigned END_HOLD_CYCLES = 65_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    game_fsm_mp_if.slave   bus
);

    localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned HOLD_W  = (END_HOLD_CYCLES > 1) ? $clog2(END_HOLD_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(END_HOLD_CYCLES - 1);
    localparam logic [3:0]         CD_INIT    = 4'(COUNTDOWN_S);

    if (COUNTDOWN_S < 1 || COUNTDOWN_S > 15) begin : g_bad_countdown
        $error("game_fsm_mp: COUNTDOWN_S must be in 1..15");
    end
    if (N_PLAYERS < 1 || N_PLAYERS > 4) begin : g_bad_players
        $error("game_fsm_mp: N_PLAYERS must be in 1..4");
    end
    if (TICKS_PER_SEC < 1 || END_HOLD_CYCLES < 1) begin : g_bad_counts
        $error("game_fsm_mp: TICKS_PER_SEC and END_HOLD_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_MENU      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_GAME      = 3'd2,
        S_PAUSE     = 3'd3,
        S_END       = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 result_q, result_d;
    logic [3:0]           cd_q, cd_d;
    logic                 entry_q;
    logic [N_PLAYERS-1:0] alive_q, alive_now;
    logic [N_PLAYERS-1:0] start_prev_q;
    logic [PRESC_W-1:0]   presc_q;
    logic [HOLD_W-1:0]    hold_q;

    logic                 state_change;
    logic                 sec_tick;
    logic                 hold_done;
    logic                 all_ready;
    logic                 boss_dead;
    logic                 any_rise;

    always_comb begin
        alive_now = '0;
        for (int unsigned i = 0; i < N_PLAYERS; i++) begin
            alive_now[i] = (bus.player_hp[i*HP_W +: HP_W] != '0);
        end
    end

    assign all_ready    = &bus.start_req;
    assign boss_dead    = (bus.boss_hp == BOSS_HP_W'(0));
    assign any_rise     = |(bus.start_req & ~start_prev_q);
    assign sec_tick     = (state_q == S_COUNTDOWN) && (presc_q == PRESC_LAST);
    assign hold_done    = (hold_q == HOLD_LAST);
    assign state_change = (state_d != state_q);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cd_d     = cd_q;
        unique case (state_q)
            S_MENU: begin
                if (all_ready) begin
                    state_d  = S_COUNTDOWN;
                    cd_d     = CD_INIT;
                    result_d = 1'b0;
                end
            end
            S_COUNTDOWN: begin
                // abort wins over a coincident second tick
                if (!all_ready) begin
                    state_d = S_MENU;
                    cd_d    = '0;
                end else if (sec_tick) begin
                    if (cd_q == 4'd1) begin
                        state_d = S_GAME;
                        cd_d    = '0;
                    end else begin
                        cd_d = cd_q - 4'd1;
                    end
                end
            end
            S_GAME: begin
                if (boss_dead) begin
                    state_d  = S_END;
                    result_d = 1'b1;
                end else if (alive_now == '0) begin
                    state_d  = S_END;
                    result_d = 1'b0;
                end else if (bus.pause_req) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (bus.pause_req) begin
                    state_d = S_GAME;
                end
            end
            S_END: begin
                if (hold_done && any_rise) begin
                    state_d  = S_COUNTDOWN;
                    cd_d     = CD_INIT;
                    result_d = 1'b0;
                end
            end
            default: begin
                state_d  = S_MENU;
                result_d = 1'b0;
                cd_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_MENU;
            result_q     <= 1'b0;
            cd_q         <= '0;
            entry_q      <= 1'b0;
            alive_q      <= '0;
            start_prev_q <= '0;
        end else begin
            state_q      <= state_d;
            result_q     <= result_d;
            cd_q         <= cd_d;
            entry_q      <= state_change;
            alive_q      <= alive_now;
            start_prev_q <= bus.start_req;
        end
    end

    // Both counters restart from zero on every state change so each state sees a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            hold_q  <= '0;
        end else begin
            if (state_change || state_q != S_COUNTDOWN || presc_q == PRESC_LAST) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PRESC_W'(1);
            end

            if (state_change || state_q != S_END) begin
                hold_q <= '0;
            end else if (!hold_done) begin
                hold_q <= hold_q + HOLD_W'(1);
            end
        end
    end

    assign bus.game_state  = state_q;
    assign bus.game_result = result_q;
    assign bus.countdown   = cd_q;
    assign bus.alive_mask  = alive_q;
    assign bus.state_entry = entry_q;

    a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
        state_q inside {S_MENU, S_COUNTDOWN, S_GAME, S_PAUSE, S_END});
    a_cd_idle_zero: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != S_COUNTDOWN) |-> (cd_q == '0));
    a_cd_range: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == S_COUNTDOWN) |-> (cd_q >= 4'd1 && cd_q <= CD_INIT));

endmodule
